// File: rtl/fifo_sync_ctrl.sv
// fifo_sync_ctrl
// Synchronous FIFO controller for a dual-port memory with a combinational
// read and a registered write. It presents a first-word-fall-through
// push/pop interface to the client and drives the memory ports.
//
// Parameters:
//   DW    - data width (must match the memory)
//   AW    - memory address width, DEPTH = 2**AW
//   AF_TH - almost_full threshold  (count >= AF_TH), 1..DEPTH
//   AE_TH - almost_empty threshold (count <= AE_TH), 0..DEPTH-1
//
// Ports:
//   clk, rst         - clock (rising edge), async active-high reset
//   push, din        - write request and data
//   pop              - consume the word currently on dout
//   dout             - head-of-FIFO data, valid while empty=0
//   full, empty, almost_full, almost_empty - registered status flags
//   count            - occupancy 0..DEPTH
//   mem_wr, mem_wa, mem_din - memory write port
//   mem_ra, mem_dout - memory read port (combinational read)
//
// Optional build macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow
// flags and a synchronous err_clr input.
module fifo_sync_ctrl #(
    parameter int unsigned DW    = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned AF_TH = 14,
    parameter int unsigned AE_TH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW:0]   count,
    output logic          mem_wr,
    output logic [AW-1:0] mem_wa,
    output logic [AW-1:0] mem_ra,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
`ifdef FIFO_ERR_FLAGS_EN
    ,
    input  logic          err_clr,
    output logic          overflow,
    output logic          underflow
`endif
);

    localparam logic [AW:0] DEPTH_V = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] AF_V    = (AW+1)'(AF_TH);
    localparam logic [AW:0] AE_V    = (AW+1)'(AE_TH);
    localparam logic [AW:0] ONE_V   = (AW+1)'(1);

    // Pointers carry an extra wrap bit; status comes from count, not
    // from comparing the pointers.
    logic [AW:0] wptr;
    logic [AW:0] rptr;
    logic [AW:0] count_nxt;
    logic        push_ok;
    logic        pop_ok;

    // Acceptance uses the registered flags, i.e. the state at this edge.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop_ok)
            count_nxt = count + ONE_V;
        else if (pop_ok && !push_ok)
            count_nxt = count - ONE_V;
    end

    // full is 0 while in reset, so the write strobe is gated explicitly.
    assign mem_wr  = push_ok & ~rst;
    assign mem_din = din;
    assign mem_wa  = wptr[AW-1:0];
    assign mem_ra  = rptr[AW-1:0];
    assign dout    = mem_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
        end else begin
            if (push_ok)
                wptr <= wptr + ONE_V;
            if (pop_ok)
                rptr <= rptr + ONE_V;
            count        <= count_nxt;
            empty        <= (count_nxt == '0);
            full         <= (count_nxt == DEPTH_V);
            almost_full  <= (count_nxt >= AF_V);
            almost_empty <= (count_nxt <= AE_V);
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    // Sticky error flags; a new error in the same cycle wins over err_clr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && full)
                overflow <= 1'b1;
            else if (err_clr)
                overflow <= 1'b0;
            if (pop && empty)
                underflow <= 1'b1;
            else if (err_clr)
                underflow <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Directed testbench for fifo_sync_ctrl (DW=16, AW=4, AF_TH=14, AE_TH=2)
// with a behavioural dual-port memory attached to the memory ports.
module tb_fifo_sync_ctrl;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          push;
    logic [DW-1:0] din;
    logic          pop;
    logic [DW-1:0] dout;
    logic          full, empty, almost_full, almost_empty;
    logic [AW:0]   count;
    logic          mem_wr;
    logic [AW-1:0] mem_wa, mem_ra;
    logic [DW-1:0] mem_din, mem_dout;
`ifdef FIFO_ERR_FLAGS_EN
    logic          err_clr;
    logic          overflow, underflow;
`endif

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] q [$];

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_wr) mem[mem_wa] <= mem_din;
    assign mem_dout = mem[mem_ra];

    fifo_sync_ctrl #(.DW(DW), .AW(AW), .AF_TH(14), .AE_TH(2)) dut (
        .clk(clk), .rst(rst), .push(push), .din(din), .pop(pop),
        .dout(dout), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .mem_wr(mem_wr), .mem_wa(mem_wa), .mem_ra(mem_ra),
        .mem_din(mem_din), .mem_dout(mem_dout)
`ifdef FIFO_ERR_FLAGS_EN
        , .err_clr(err_clr), .overflow(overflow), .underflow(underflow)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        push = 1'b0; pop = 1'b0; din = '0; rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; push = 1'b1; pop = 1'b0; din = 16'h5555;
`ifdef FIFO_ERR_FLAGS_EN
        err_clr = 1'b0;
`endif
        tick();
        tests++; if (mem_wr !== 1'b0) begin fails++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
        push = 1'b0;
        tick();
        rst = 1'b0;
        tick(); tick();
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b want 1", empty); end
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b want 0", full); end
        tests++; if (count !== 5'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
        tests++; if (almost_empty !== 1'b1) begin fails++; $display("FAIL reset_ae: got %b want 1", almost_empty); end
        tests++; if (almost_full !== 1'b0) begin fails++; $display("FAIL reset_af: got %b want 0", almost_full); end
        tests++; if (mem_wr !== 1'b0) begin fails++; $display("FAIL reset_idle_mem_wr: got %b want 0", mem_wr); end
`ifdef FIFO_ERR_FLAGS_EN
        tests++; if ({overflow, underflow} !== 2'b00) begin fails++; $display("FAIL reset_err: got %b want 00", {overflow, underflow}); end
`endif
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 16; i++) begin
            push = 1'b1; din = DW'(i);
            #1;
            tests++; if (mem_wr !== 1'b1) begin fails++; $display("FAIL fill_mem_wr[%0d]: got %b want 1", i, mem_wr); end
            tick();
            tests++; if (count !== 5'(i)) begin fails++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, count, i); end
            tests++; if (almost_full !== (i >= 14)) begin fails++; $display("FAIL fill_af[%0d]: got %b want %b", i, almost_full, i >= 14); end
            tests++; if (full !== (i == 16)) begin fails++; $display("FAIL fill_full[%0d]: got %b want %b", i, full, i == 16); end
            tests++; if (almost_empty !== (i <= 2)) begin fails++; $display("FAIL fill_ae[%0d]: got %b want %b", i, almost_empty, i <= 2); end
            tests++; if (empty !== 1'b0) begin fails++; $display("FAIL fill_empty[%0d]: got %b want 0", i, empty); end
        end
        push = 1'b1; din = 16'hDEAD;
        #1;
        tests++; if (mem_wr !== 1'b0) begin fails++; $display("FAIL overflow_mem_wr: got %b want 0", mem_wr); end
        tick();
        push = 1'b0;
        tests++; if (count !== 5'd16) begin fails++; $display("FAIL overflow_count: got %0d want 16", count); end
        tests++; if (dout !== 16'h0001) begin fails++; $display("FAIL overflow_head: got %h want 0001", dout); end
`ifdef FIFO_ERR_FLAGS_EN
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL overflow_flag: got %b want 1", overflow); end
`endif
    endtask

    task automatic test_drain();
        for (int i = 1; i <= 16; i++) begin
            tests++; if (dout !== DW'(i)) begin fails++; $display("FAIL drain_dout[%0d]: got %h want %h", i, dout, DW'(i)); end
            pop = 1'b1;
            tick();
            tests++; if (count !== 5'(16 - i)) begin fails++; $display("FAIL drain_count[%0d]: got %0d want %0d", i, count, 16 - i); end
            tests++; if (empty !== (i == 16)) begin fails++; $display("FAIL drain_empty[%0d]: got %b want %b", i, empty, i == 16); end
        end
        tick();
        pop = 1'b0;
        tests++; if (count !== 5'd0) begin fails++; $display("FAIL underflow_count: got %0d want 0", count); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL underflow_empty: got %b want 1", empty); end
`ifdef FIFO_ERR_FLAGS_EN
        tests++; if (underflow !== 1'b1) begin fails++; $display("FAIL underflow_flag: got %b want 1", underflow); end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        tests++; if ({overflow, underflow} !== 2'b00) begin fails++; $display("FAIL err_clr: got %b want 00", {overflow, underflow}); end
`endif
    endtask

    task automatic test_simultaneous();
        push = 1'b1; pop = 1'b1; din = 16'hA5A5;
        tick();
        push = 1'b0; pop = 1'b0;
        tests++; if (count !== 5'd1) begin fails++; $display("FAIL simul_empty_count: got %0d want 1", count); end
        tests++; if (empty !== 1'b0) begin fails++; $display("FAIL simul_empty_flag: got %b want 0", empty); end
        tests++; if (dout !== 16'hA5A5) begin fails++; $display("FAIL simul_empty_dout: got %h want a5a5", dout); end
        for (int k = 1; k <= 15; k++) begin
            push = 1'b1; din = DW'(16'h0100 + k);
            tick();
        end
        tests++; if (full !== 1'b1) begin fails++; $display("FAIL simul_full_pre: got %b want 1", full); end
        push = 1'b1; pop = 1'b1; din = 16'hBEEF;
        #1;
        tests++; if (mem_wr !== 1'b0) begin fails++; $display("FAIL simul_full_mem_wr: got %b want 0", mem_wr); end
        tick();
        push = 1'b0; pop = 1'b0;
        tests++; if (count !== 5'd15) begin fails++; $display("FAIL simul_full_count: got %0d want 15", count); end
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL simul_full_flag: got %b want 0", full); end
        tests++; if (dout !== 16'h0101) begin fails++; $display("FAIL simul_full_head: got %h want 0101", dout); end
    endtask

    task automatic test_stream();
        do_reset();
        q.delete();
        for (int k = 0; k < 8; k++) begin
            push = 1'b1; din = DW'(16'h2000 + k);
            q.push_back(din);
            tick();
        end
        for (int k = 0; k < 40; k++) begin
            push = 1'b1; pop = 1'b1; din = DW'(16'h2008 + k);
            #1;
            tests++; if (dout !== q[0]) begin fails++; $display("FAIL stream_dout[%0d]: got %h want %h", k, dout, q[0]); end
            tick();
            void'(q.pop_front());
            q.push_back(din);
            tests++; if (count !== 5'd8) begin fails++; $display("FAIL stream_count[%0d]: got %0d want 8", k, count); end
        end
        push = 1'b0; pop = 1'b0;
        // 48 pushes and 40 pops: write slot 0, read slot 8.
        tests++; if (mem_wa !== 4'd0) begin fails++; $display("FAIL stream_wa: got %0d want 0", mem_wa); end
        tests++; if (mem_ra !== 4'd8) begin fails++; $display("FAIL stream_ra: got %0d want 8", mem_ra); end
        for (int k = 0; k < 8; k++) begin
            tests++; if (dout !== q[0]) begin fails++; $display("FAIL stream_tail[%0d]: got %h want %h", k, dout, q[0]); end
            pop = 1'b1;
            tick();
            void'(q.pop_front());
        end
        pop = 1'b0;
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL stream_empty: got %b want 1", empty); end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 9; k++) begin
            push = 1'b1; din = DW'(16'h3000 + k);
            tick();
        end
        tests++; if (count !== 5'd9) begin fails++; $display("FAIL arst_pre_count: got %0d want 9", count); end
        push = 1'b1; din = 16'h3009;
        #3;
        rst = 1'b1;
        #1;
        tests++; if (count !== 5'd0) begin fails++; $display("FAIL arst_count: got %0d want 0", count); end
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL arst_empty: got %b want 1", empty); end
        tests++; if (almost_empty !== 1'b1) begin fails++; $display("FAIL arst_ae: got %b want 1", almost_empty); end
        tests++; if (full !== 1'b0 || almost_full !== 1'b0) begin fails++; $display("FAIL arst_full_af: got %b%b want 00", full, almost_full); end
        tests++; if (mem_wr !== 1'b0) begin fails++; $display("FAIL arst_mem_wr: got %b want 0", mem_wr); end
        tests++; if (mem_ra !== 4'd0 || mem_wa !== 4'd0) begin fails++; $display("FAIL arst_ptrs: got ra=%0d wa=%0d want 0 0", mem_ra, mem_wa); end
        push = 1'b0;
        tick();
        rst = 1'b0;
        push = 1'b1; din = 16'h1234;
        tick();
        push = 1'b0;
        tests++; if (count !== 5'd1) begin fails++; $display("FAIL arst_after_count: got %0d want 1", count); end
        tests++; if (dout !== 16'h1234) begin fails++; $display("FAIL arst_after_dout: got %h want 1234", dout); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_simultaneous();
        test_stream();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
